// File: rtl/aap_fetch_unit.sv
// AAP instruction fetch stage: reads 16-bit words, assembles 16/32-bit instructions,
// presents them to decode under valid/ready and handles branch redirect with flush.
module aap_fetch_unit #(
    parameter int unsigned             ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [15:0]           imem_rdata,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [31:0]           fetchoutput,
    output logic                  fetch_is32,
    output logic                  fetch_illegal,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_valid,
    input  logic                  decode_ready
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_LO = 3'd1,
        FETCH_HI = 3'd2,
        HOLD     = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [15:0]           lo, lo_n;
    logic                  req_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [31:0]           out_n;
    logic                  is32_n, ill_n, valid_n;
    logic [ADDR_WIDTH-1:0] fpc_n;

    logic                  rv;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Response only counts against an outstanding request.
    assign rv        = imem_rvalid & imem_req;
    assign handshake = fetch_valid & decode_ready;
    assign pc_inc    = pc + ADDR_WIDTH'(1);

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            lo            <= 16'h0000;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            fetchoutput   <= 32'h0000_0000;
            fetch_is32    <= 1'b0;
            fetch_illegal <= 1'b0;
            fetch_pc      <= '0;
            fetch_valid   <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            lo            <= lo_n;
            imem_req      <= req_n;
            imem_addr     <= addr_n;
            fetchoutput   <= out_n;
            fetch_is32    <= is32_n;
            fetch_illegal <= ill_n;
            fetch_pc      <= fpc_n;
            fetch_valid   <= valid_n;
        end
    end

    // Next-state and next-output logic; redirect outranks everything but reset.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        lo_n    = lo;
        req_n   = imem_req;
        addr_n  = imem_addr;
        out_n   = fetchoutput;
        is32_n  = fetch_is32;
        ill_n   = fetch_illegal;
        fpc_n   = fetch_pc;
        valid_n = fetch_valid;

        unique case (state)
            IDLE: begin
                if (branch_valid) begin
                    pc_n = branch_target;
                end
                state_n = FETCH_LO;
                req_n   = 1'b1;
                addr_n  = pc_n;
            end

            FETCH_LO, FETCH_HI: begin
                if (branch_valid) begin
                    pc_n = branch_target;
                    if (rv) begin
                        state_n = FETCH_LO;
                        req_n   = 1'b1;
                        addr_n  = branch_target;
                    end else begin
                        // Request still in flight: keep it on the bus, drop its data later.
                        state_n = DRAIN;
                    end
                end else if (rv) begin
                    pc_n = pc_inc;
                    if (state == FETCH_LO) begin
                        lo_n  = imem_rdata;
                        fpc_n = pc;
                        if (!imem_rdata[15]) begin
                            state_n = HOLD;
                            out_n   = {16'h0000, imem_rdata};
                            is32_n  = 1'b0;
                            ill_n   = 1'b0;
                            valid_n = 1'b1;
                            req_n   = 1'b0;
                        end else begin
                            state_n = FETCH_HI;
                            addr_n  = pc_inc;
                        end
                    end else begin
                        state_n = HOLD;
                        out_n   = {imem_rdata, lo};
                        is32_n  = 1'b1;
                        ill_n   = ~imem_rdata[15];
                        valid_n = 1'b1;
                        req_n   = 1'b0;
                    end
                end
            end

            HOLD: begin
                if (branch_valid) begin
                    pc_n    = branch_target;
                    state_n = FETCH_LO;
                    valid_n = 1'b0;
                    req_n   = 1'b1;
                    addr_n  = branch_target;
                end else if (handshake) begin
                    state_n = FETCH_LO;
                    valid_n = 1'b0;
                    req_n   = 1'b1;
                    addr_n  = pc;
                end
            end

            DRAIN: begin
                if (branch_valid) begin
                    pc_n = branch_target;
                end
                if (rv) begin
                    state_n = FETCH_LO;
                    req_n   = 1'b1;
                    addr_n  = pc_n;
                end
            end

            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aap_fetch_unit.sv
// Directed bench for aap_fetch_unit: vector table for a straight-line stream,
// plus hand sequences for stall, redirect, PC wrap and mid-fetch reset.
module tb_aap_fetch_unit;

    localparam int unsigned AW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [15:0]   imem_rdata;
    logic          branch_valid;
    logic [AW-1:0] branch_target;
    logic [31:0]   fetchoutput;
    logic          fetch_is32;
    logic          fetch_illegal;
    logic [AW-1:0] fetch_pc;
    logic          fetch_valid;
    logic          decode_ready;

    aap_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(24'h000000)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .fetchoutput   (fetchoutput),
        .fetch_is32    (fetch_is32),
        .fetch_illegal (fetch_illegal),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .decode_ready  (decode_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    always @(posedge clock) cyc <= cyc + 1;

    logic [15:0] mem [logic [AW-1:0]];

    function automatic logic [15:0] rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    // Memory model: rvalid 'lat' cycles after the request is first seen, one pulse per request.
    int cnt = 0;
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        forever begin
            @(posedge clock);
            #1;
            if (imem_rvalid) begin
                imem_rvalid = 1'b0;
                cnt = 0;
            end
            if (imem_req) begin
                if (cnt >= lat) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rd(imem_addr);
                    cnt = 0;
                end else begin
                    cnt = cnt + 1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (fetch_valid) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s timeout waiting for fetch_valid actual=0 required=1", name);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'h0);
        chk({tag, "_addr"},  32'(imem_addr), 32'h0);
        chk({tag, "_valid"}, 32'(fetch_valid), 32'h0);
        chk({tag, "_out"},   fetchoutput, 32'h0);
        chk({tag, "_is32"},  32'(fetch_is32), 32'h0);
        chk({tag, "_ill"},   32'(fetch_illegal), 32'h0);
        chk({tag, "_pc"},    32'(fetch_pc), 32'h0);
    endtask

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   out;
        logic          is32;
        logic          ill;
        logic [AW-1:0] next;
        int            gap;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int prev_cyc;
        bit found;
        logic [31:0] held;

        vecs[0] = '{24'd0,  32'h0000_1234, 1'b0, 1'b0, 24'd1,  0};
        vecs[1] = '{24'd1,  32'h0000_0001, 1'b0, 1'b0, 24'd2,  3};
        vecs[2] = '{24'd2,  32'h0000_7FFF, 1'b0, 1'b0, 24'd3,  3};
        vecs[3] = '{24'd3,  32'h0000_0000, 1'b0, 1'b0, 24'd4,  3};
        vecs[4] = '{24'd4,  32'h8005_8A01, 1'b1, 1'b0, 24'd6,  5};
        vecs[5] = '{24'd6,  32'h0005_8A01, 1'b1, 1'b1, 24'd8,  5};
        vecs[6] = '{24'd8,  32'hFFFF_FFFF, 1'b1, 1'b0, 24'd10, 5};
        vecs[7] = '{24'd10, 32'h0000_4321, 1'b0, 1'b0, 24'd11, 3};

        mem[24'd0]  = 16'h1234;
        mem[24'd1]  = 16'h0001;
        mem[24'd2]  = 16'h7FFF;
        mem[24'd3]  = 16'h0000;
        mem[24'd4]  = 16'h8A01;
        mem[24'd5]  = 16'h8005;
        mem[24'd6]  = 16'h8A01;
        mem[24'd7]  = 16'h0005;
        mem[24'd8]  = 16'hFFFF;
        mem[24'd9]  = 16'hFFFF;
        mem[24'd10] = 16'h4321;
        mem[24'd11] = 16'h0ABC;
        mem[24'd12] = 16'h1111;
        mem[24'h000100] = 16'h0042;
        mem[24'h000200] = 16'h0777;
        mem[24'hFFFFFF] = 16'h8000;

        reset         = 1'b1;
        branch_valid  = 1'b0;
        branch_target = '0;
        decode_ready  = 1'b1;

        repeat (3) step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step();
        chk("start_req", 32'(imem_req), 32'h1);
        chk("start_addr", 32'(imem_addr), 32'h0);

        // Straight-line stream with decode always ready.
        prev_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_out", i),  fetchoutput, vecs[i].out);
            chk($sformatf("vec%0d_is32", i), 32'(fetch_is32), 32'(vecs[i].is32));
            chk($sformatf("vec%0d_ill", i),  32'(fetch_illegal), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_pc", i),   32'(fetch_pc), 32'(vecs[i].pc));
            chk($sformatf("vec%0d_req", i),  32'(imem_req), 32'h0);
            if (vecs[i].gap != 0)
                chk($sformatf("vec%0d_gap", i), 32'(cyc - prev_cyc), 32'(vecs[i].gap));
            prev_cyc = cyc;
            step();
            chk($sformatf("vec%0d_valid_drop", i), 32'(fetch_valid), 32'h0);
            chk($sformatf("vec%0d_next_req", i),   32'(imem_req), 32'h1);
            chk($sformatf("vec%0d_next_addr", i),  32'(imem_addr), 32'(vecs[i].next));
        end

        // Decode stall: outputs frozen, no request issued.
        decode_ready = 1'b0;
        wait_valid("stall");
        held = fetchoutput;
        chk("stall_out", fetchoutput, 32'h0000_0ABC);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall%0d_valid", i), 32'(fetch_valid), 32'h1);
            chk($sformatf("stall%0d_out", i), fetchoutput, held);
            chk($sformatf("stall%0d_req", i), 32'(imem_req), 32'h0);
            chk($sformatf("stall%0d_pc", i), 32'(fetch_pc), 32'd11);
        end
        lat = 3;
        decode_ready = 1'b1;
        step();
        chk("unstall_valid", 32'(fetch_valid), 32'h0);
        chk("unstall_addr", 32'(imem_addr), 32'd12);

        // Redirect while the request to 12 is outstanding: it must drain, not deliver.
        branch_valid  = 1'b1;
        branch_target = 24'h000100;
        step();
        branch_valid = 1'b0;
        chk("drain_req0", 32'(imem_req), 32'h1);
        chk("drain_addr0", 32'(imem_addr), 32'd12);
        step();
        chk("drain_req1", 32'(imem_req), 32'h1);
        chk("drain_addr1", 32'(imem_addr), 32'd12);
        wait_valid("br_outstanding");
        chk("br_out", fetchoutput, 32'h0000_0042);
        chk("br_pc", 32'(fetch_pc), 32'h000100);

        // Redirect in HOLD coincident with a handshake.
        lat = 1;
        branch_valid  = 1'b1;
        branch_target = 24'h000200;
        step();
        branch_valid = 1'b0;
        chk("hold_br_valid", 32'(fetch_valid), 32'h0);
        chk("hold_br_addr", 32'(imem_addr), 32'h000200);
        wait_valid("hold_br");
        chk("hold_br_out", fetchoutput, 32'h0000_0777);
        chk("hold_br_pc", 32'(fetch_pc), 32'h000200);

        // 32-bit instruction straddling the PC wrap.
        mem[24'd0] = 16'h8001;
        mem[24'd1] = 16'h9000;
        branch_valid  = 1'b1;
        branch_target = 24'hFFFFFF;
        step();
        branch_valid = 1'b0;
        chk("wrap_addr", 32'(imem_addr), 32'h00FFFFFF);
        wait_valid("wrap");
        chk("wrap_out", fetchoutput, 32'h8001_8000);
        chk("wrap_is32", 32'(fetch_is32), 32'h1);
        chk("wrap_ill", 32'(fetch_illegal), 32'h0);
        chk("wrap_pc", 32'(fetch_pc), 32'h00FFFFFF);
        step();
        chk("wrap_next_addr", 32'(imem_addr), 32'd1);

        // Reset while fetching the second word of an instruction.
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req && imem_addr == 24'd2) begin
                found = 1;
                break;
            end
        end
        chk("reach_fetch_hi", 32'(found), 32'h1);
        reset = 1'b1;
        step();
        chk_reset_vals("midreset");
        reset = 1'b0;
        step();
        chk("post_reset_req", 32'(imem_req), 32'h1);
        chk("post_reset_addr", 32'(imem_addr), 32'h0);
        wait_valid("post_reset");
        chk("post_reset_out", fetchoutput, 32'h9000_8001);
        chk("post_reset_pc", 32'(fetch_pc), 32'h0);
        chk("post_reset_is32", 32'(fetch_is32), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
